snake_dir_queue: RTL and testbench

SNAKE_DIR_QUEUE -- requirements
Module: snake_dir_queue

---
 rtl/snake_dir_queue.sv | 176 +++++++++++++++++
 tb/tb_snake_dir_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_queue.sv
// Direction command queue for a snake game.
// Button presses are edge-detected, priority-resolved and filtered against the
// newest pending direction; accepted commands wait in a small circular buffer
// and are applied to cobra_dir one per game step.
module snake_dir_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         step,
  output logic [1:0]                   cobra_dir,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         drop
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  // Direction encoding: 00 up, 01 down, 10 left, 11 right.
  // Opposite directions share bit 1, so "same axis" is a bit-1 compare.

  // Command contract: a press is offered (w_press_valid) for one cycle only;
  // it is taken (w_push) when it turns the snake onto the other axis and a
  // slot is free or being freed by a same-cycle step. An offered, axis-legal
  // press that cannot be taken raises drop for the following cycle. A step is
  // always consumed; it pops the head only when something is queued.

  logic [3:0]    r_prev;
  logic [1:0]    r_dir;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_drop;
  logic [1:0]    r_q [DEPTH];

  logic [3:0]    w_btn;
  logic [3:0]    w_rise;
  logic          w_press_valid;
  logic [1:0]    w_press_dir;
  logic [PW-1:0] w_newest_ptr;
  logic [1:0]    w_ref_dir;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Advance a buffer pointer with wrap at DEPTH-1.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + 1'b1;
    end
  endfunction

  assign w_btn  = {up, down, left, right};
  assign w_rise = w_btn & ~r_prev;

  // Resolve simultaneous rising edges: up > down > left > right.
  always_comb begin
    w_press_valid = 1'b0;
    w_press_dir   = 2'b00;
    if (w_rise[3]) begin
      w_press_valid = 1'b1;
      w_press_dir   = 2'b00;
    end else if (w_rise[2]) begin
      w_press_valid = 1'b1;
      w_press_dir   = 2'b01;
    end else if (w_rise[1]) begin
      w_press_valid = 1'b1;
      w_press_dir   = 2'b10;
    end else if (w_rise[0]) begin
      w_press_valid = 1'b1;
      w_press_dir   = 2'b11;
    end
  end

  // Locate the most recently written entry (one behind the tail).
  always_comb begin
    if (r_tail == '0) begin
      w_newest_ptr = LAST_PTR;
    end else begin
      w_newest_ptr = r_tail - 1'b1;
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_ref_dir = w_empty ? r_dir : r_q[w_newest_ptr];

  // A press is legal only when it turns onto the other axis.
  assign w_accept = w_press_valid & (w_press_dir[1] != w_ref_dir[1]);
  assign w_pop    = step & ~w_empty;
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_drop   = w_accept & w_full & ~step;

  // Remember the previous button levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 4'b0000;
    end else begin
      r_prev <= w_btn;
    end
  end

  // Apply the head command to the movement direction on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= INIT_DIR;
    end else if (w_pop) begin
      r_dir <= r_q[r_head];
    end
  end

  // Queue storage: write accepted commands at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= 2'b00;
      end
    end else if (w_push) begin
      r_q[r_tail] <= w_press_dir;
    end
  end

  // Head/tail pointers wrap around the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
      if (w_push) begin
        r_tail <= next_ptr(r_tail);
      end
    end
  end

  // Occupancy: push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle pulse reporting a legal command lost to a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop;
    end
  end

  assign cobra_dir = r_dir;
  assign q_count   = r_count;
  assign drop      = r_drop;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_snake_dir_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          up, down, left, right;
  logic          step;
  logic [1:0]    cobra_dir;
  logic [CW-1:0] q_count;
  logic          drop;

  int n_vec;
  int n_err;

  // Reference model state
  logic [1:0] m_q[$];
  logic [1:0] m_dir;
  logic [3:0] m_prev;
  logic       m_drop;

  snake_dir_queue #(.DEPTH(DEPTH), .INIT_DIR(2'b11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .step      (step),
    .cobra_dir (cobra_dir),
    .q_count   (q_count),
    .drop      (drop)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_dir  = 2'b11;
    m_prev = 4'b0000;
    m_drop = 1'b0;
  endtask

  // One clock of game behaviour, from the rules: first rising button by
  // priority, must turn onto the other axis relative to the newest pending
  // direction, step pops the oldest command first, and a press finding no
  // room is reported as dropped.
  task automatic model_step(input logic [3:0] b, input logic s);
    logic [3:0] rise;
    logic       have;
    logic [1:0] d;
    logic [1:0] refd;
    rise   = b & ~m_prev;
    m_prev = b;
    have   = 1'b1;
    d      = 2'b00;
    if (rise[3])      d = 2'b00;
    else if (rise[2]) d = 2'b01;
    else if (rise[1]) d = 2'b10;
    else if (rise[0]) d = 2'b11;
    else              have = 1'b0;
    refd   = (m_q.size() > 0) ? m_q[$] : m_dir;
    m_drop = 1'b0;
    if (s && m_q.size() > 0) m_dir = m_q.pop_front();
    if (have && ((d >> 1) != (refd >> 1))) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_drop = 1'b1;
    end
  endtask

  // Drive one cycle of inputs ({up,down,left,right}, step), then sample
  // just after the rising edge.
  task automatic drive(input logic [3:0] b, input logic s);
    {up, down, left, right} = b;
    step = s;
    model_step(b, s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {up, down, left, right} = 4'b0000;
    step = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {up, down, left, right} = 4'b1111;
    step = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (cobra_dir !== 2'b11) begin
      $display("FAIL reset_dir: got %0d want 3", cobra_dir); n_err++;
    end
    n_vec++;
    if (q_count !== 2'd0) begin
      $display("FAIL reset_count: got %0d want 0", q_count); n_err++;
    end
    n_vec++;
    if (drop !== 1'b0) begin
      $display("FAIL reset_drop: got %0d want 0", drop); n_err++;
    end
    do_reset();
  endtask

  task automatic test_press_step();
    do_reset();
    drive(4'b1000, 1'b0);
    n_vec++;
    if (q_count !== 2'd1) begin
      $display("FAIL press_up_count: got %0d want 1", q_count); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b00) begin
      $display("FAIL step_dir: got %0d want 0", cobra_dir); n_err++;
    end
    n_vec++;
    if (q_count !== 2'd0) begin
      $display("FAIL step_count: got %0d want 0", q_count); n_err++;
    end
    // Step with an empty queue keeps the direction.
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b00) begin
      $display("FAIL empty_step_dir: got %0d want 0", cobra_dir); n_err++;
    end
  endtask

  task automatic test_reject_hold();
    do_reset();
    drive(4'b0010, 1'b0);
    n_vec++;
    if (q_count !== 2'd0) begin
      $display("FAIL reject_left: got %0d want 0", q_count); n_err++;
    end
    drive(4'b0000, 1'b0);
    drive(4'b0001, 1'b0);
    n_vec++;
    if (q_count !== 2'd0 || drop !== 1'b0) begin
      $display("FAIL reject_right: count %0d drop %0d want 0 0", q_count, drop); n_err++;
    end
    drive(4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) drive(4'b1000, 1'b0);
    n_vec++;
    if (q_count !== 2'd1) begin
      $display("FAIL hold_up: got %0d want 1", q_count); n_err++;
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0010, 1'b0);
    n_vec++;
    if (q_count !== 2'd2) begin
      $display("FAIL fill_count: got %0d want 2", q_count); n_err++;
    end
    drive(4'b0000, 1'b0);
    drive(4'b0100, 1'b0);
    n_vec++;
    if (drop !== 1'b1 || q_count !== 2'd2) begin
      $display("FAIL full_drop: drop %0d count %0d want 1 2", drop, q_count); n_err++;
    end
    drive(4'b0000, 1'b0);
    n_vec++;
    if (drop !== 1'b0) begin
      $display("FAIL drop_pulse: got %0d want 0", drop); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b00) begin
      $display("FAIL drain1_dir: got %0d want 0", cobra_dir); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b10 || q_count !== 2'd0) begin
      $display("FAIL drain2: dir %0d count %0d want 2 0", cobra_dir, q_count); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0010, 1'b0);
    // Full queue [up,left]; step with an accepted down press.
    drive(4'b0100, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b00 || q_count !== 2'd2 || drop !== 1'b0) begin
      $display("FAIL full_step_push: dir %0d count %0d drop %0d want 0 2 0",
               cobra_dir, q_count, drop); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b10) begin
      $display("FAIL b2b_left: got %0d want 2", cobra_dir); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b01 || q_count !== 2'd0) begin
      $display("FAIL b2b_down: dir %0d count %0d want 1 0", cobra_dir, q_count); n_err++;
    end
    // Empty queue: a press with a step is queued, not bypassed.
    do_reset();
    drive(4'b1000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b11 || q_count !== 2'd1) begin
      $display("FAIL empty_step_push: dir %0d count %0d want 3 1", cobra_dir, q_count); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b00) begin
      $display("FAIL empty_step_next: got %0d want 0", cobra_dir); n_err++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(4'b1010, 1'b0);
    n_vec++;
    if (q_count !== 2'd1) begin
      $display("FAIL prio_count: got %0d want 1", q_count); n_err++;
    end
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b00) begin
      $display("FAIL prio_dir: got %0d want 0", cobra_dir); n_err++;
    end
    // Down wins over right but is rejected; right must not be taken instead.
    drive(4'b0101, 1'b0);
    n_vec++;
    if (q_count !== 2'd0) begin
      $display("FAIL prio_discard: got %0d want 0", q_count); n_err++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0010, 1'b0);
    #3;
    rst_n = 1'b0;
    {up, down, left, right} = 4'b0000;
    model_reset();
    #1;
    n_vec++;
    if (cobra_dir !== 2'b11 || q_count !== 2'd0 || drop !== 1'b0) begin
      $display("FAIL async_reset: dir %0d count %0d drop %0d want 3 0 0",
               cobra_dir, q_count, drop); n_err++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(4'b0000, 1'b1);
    n_vec++;
    if (cobra_dir !== 2'b11 || q_count !== 2'd0) begin
      $display("FAIL async_reset_step: dir %0d count %0d want 3 0", cobra_dir, q_count); n_err++;
    end
  endtask

  task automatic test_held_through_reset();
    rst_n = 1'b0;
    {up, down, left, right} = 4'b1000;
    step = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(4'b1000, 1'b0);
    n_vec++;
    if (q_count !== 2'd1) begin
      $display("FAIL held_reset_press: got %0d want 1", q_count); n_err++;
    end
    drive(4'b1000, 1'b0);
    n_vec++;
    if (q_count !== 2'd1) begin
      $display("FAIL held_reset_hold: got %0d want 1", q_count); n_err++;
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic       s;
    do_reset();
    b = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) b = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 3) == 0);
      drive(b, s);
      n_vec++;
      if (cobra_dir !== m_dir) begin
        $display("FAIL rand_dir[%0d]: got %0d want %0d", i, cobra_dir, m_dir); n_err++;
      end
      n_vec++;
      if (q_count !== CW'(m_q.size())) begin
        $display("FAIL rand_count[%0d]: got %0d want %0d", i, q_count, m_q.size()); n_err++;
      end
      n_vec++;
      if (drop !== m_drop) begin
        $display("FAIL rand_drop[%0d]: got %0d want %0d", i, drop, m_drop); n_err++;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {up, down, left, right} = 4'b0000;
    step = 1'b0;
    model_reset();
    test_reset();
    test_press_step();
    test_reject_hold();
    test_full_drop();
    test_back_to_back();
    test_priority();
    test_async_reset();
    test_held_through_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
